// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, ALU op codes, fixed destinations
// and the datapath control bundle produced by the decoder.
package isa_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b000;
    localparam logic [2:0] OPC_LD   = 3'b001;
    localparam logic [2:0] OPC_ST   = 3'b010;
    localparam logic [2:0] OPC_RXOR = 3'b011;
    localparam logic [2:0] OPC_ADDI = 3'b100;
    localparam logic [2:0] OPC_LSR  = 3'b101;
    localparam logic [2:0] OPC_ADD  = 3'b110;
    localparam logic [2:0] OPC_BEQR = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_BEQ  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_RXOR = 3'd3;
    localparam logic [2:0] ALU_PM   = 3'd4;
    localparam logic [2:0] ALU_LSL  = 3'd5;
    localparam logic [2:0] ALU_LSR  = 3'd6;

    localparam logic [3:0] DEST_MOV = 4'd8;
    localparam logic [3:0] DEST_ADD = 4'd9;
    localparam logic [3:0] DEST_IMM = 4'd10;
    localparam logic [3:0] DEST_SFT = 4'd11;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic alu_src;
        logic move;
        logic copy;
        logic load;
        logic branch;
        logic d;
    } ctrl_t;

endpackage

// File: rtl/decode_core.sv
// Pure combinational instruction decode: controls, ALU op, destination and
// the scoreboard source register, if the instruction has one.
module decode_core
    import isa_pkg::*;
#(
    parameter int IW  = 9,
    parameter int RAW = 4
) (
    input  logic [IW-1:0]  instr_i,
    output ctrl_t          ctrl_o,
    output logic [2:0]     op_o,
    output logic [RAW-1:0] dest_o,
    output logic           reads_src_o,
    output logic [2:0]     src_o
);
    logic [2:0] opc;
    logic       sub;

    assign opc   = instr_i[IW-1:IW-3];
    assign sub   = instr_i[IW-4];
    assign src_o = instr_i[2:0];

    always_comb begin
        ctrl_o      = '0;
        op_o        = ALU_ADD;
        dest_o      = '0;
        reads_src_o = 1'b0;
        unique case (opc)
            OPC_MOV: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.move      = 1'b1;
                dest_o           = RAW'(DEST_MOV);
                reads_src_o      = 1'b1;
            end
            OPC_LD: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.load      = 1'b1;
                dest_o           = RAW'(instr_i[5:3]);
                reads_src_o      = 1'b1;
            end
            OPC_ST: begin
                ctrl_o.mem_write = 1'b1;
                reads_src_o      = 1'b1;
            end
            OPC_RXOR: begin
                op_o             = ALU_RXOR;
                ctrl_o.reg_write = 1'b1;
                dest_o           = RAW'(instr_i[2:0]);
                reads_src_o      = 1'b1;
            end
            OPC_ADD: begin
                op_o             = sub ? ALU_XOR : ALU_ADD;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                dest_o           = sub ? RAW'(DEST_SFT) : RAW'(DEST_ADD);
            end
            OPC_BEQR: begin
                if (sub) begin
                    // copy reads a D register, which the scoreboard never tracks
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.copy      = 1'b1;
                    ctrl_o.d         = 1'b1;
                    dest_o           = RAW'(instr_i[2:0]);
                end else begin
                    op_o          = ALU_BEQ;
                    ctrl_o.branch = 1'b1;
                end
            end
            OPC_ADDI: begin
                op_o             = sub ? ALU_LSL : ALU_ADD;
                ctrl_o.reg_write = 1'b1;
                dest_o           = sub ? RAW'(DEST_SFT) : RAW'(DEST_IMM);
            end
            default: begin
                op_o             = sub ? ALU_PM : ALU_LSR;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = sub;
                dest_o           = sub ? RAW'(DEST_ADD) : RAW'(DEST_SFT);
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register, load-use scoreboard
// over the eight low registers, and a saturating hazard-stall counter.
module decode_stage
    import isa_pkg::*;
#(
    parameter int IW  = 9,
    parameter int RAW = 4,
    parameter int CW  = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [IW-1:0]  in_instr_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2:0]     out_op_o,
    output logic           out_reg_write_o,
    output logic           out_mem_write_o,
    output logic           out_alu_src_o,
    output logic           out_move_o,
    output logic           out_copy_o,
    output logic           out_load_o,
    output logic           out_branch_o,
    output logic           out_d_o,
    output logic [RAW-1:0] out_dest_o,
    output logic [IW-1:0]  out_instr_o,
    input  logic           wb_valid_i,
    input  logic [RAW-1:0] wb_dest_i,
    output logic [CW-1:0]  stall_count_o
);
    ctrl_t          dec_ctrl, ctrl_q;
    logic [2:0]     dec_op, op_q, dec_src;
    logic [RAW-1:0] dec_dest, dest_q;
    logic           dec_reads;
    logic [IW-1:0]  instr_q;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     pending_q, pending_d, pend_set, pend_clr;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hazard, accept;

    decode_core #(.IW(IW), .RAW(RAW)) u_core (
        .instr_i     (in_instr_i),
        .ctrl_o      (dec_ctrl),
        .op_o        (dec_op),
        .dest_o      (dec_dest),
        .reads_src_o (dec_reads),
        .src_o       (dec_src)
    );

    // pending is used as registered: a write-back only unblocks next cycle
    assign hazard     = in_valid_i && dec_reads && pending_q[dec_src];
    assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (accept && dec_ctrl.load) pend_set = 8'b1 << dec_dest[2:0];
        if (wb_valid_i && (wb_dest_i < RAW'(8))) pend_clr = 8'b1 << wb_dest_i[2:0];
        pending_d = (pending_q & ~pend_clr) | pend_set;

        out_valid_d = out_valid_q;
        if (accept)           out_valid_d = 1'b1;
        else if (out_ready_i) out_valid_d = 1'b0;

        cnt_d = cnt_q;
        if (hazard && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            op_q        <= '0;
            dest_q      <= '0;
            instr_q     <= '0;
            pending_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                ctrl_q  <= dec_ctrl;
                op_q    <= dec_op;
                dest_q  <= dec_dest;
                instr_q <= in_instr_i;
            end
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_op_o        = op_q;
    assign out_dest_o      = dest_q;
    assign out_instr_o     = instr_q;
    assign out_reg_write_o = ctrl_q.reg_write;
    assign out_mem_write_o = ctrl_q.mem_write;
    assign out_alu_src_o   = ctrl_q.alu_src;
    assign out_move_o      = ctrl_q.move;
    assign out_copy_o      = ctrl_q.copy;
    assign out_load_o      = ctrl_q.load;
    assign out_branch_o    = ctrl_q.branch;
    assign out_d_o         = ctrl_q.d;
    assign stall_count_o   = cnt_q;

endmodule
